// File: rtl/uart_pkg.sv
// Shared constants for the UART status-LED block.
//   DATA_W_DEF  : default width of the received word / display field
//   LED_*       : bit offsets of the status LEDs above the DATA_W display field,
//                 i.e. led[DATA_W + LED_RX_ACT] is the RX activity LED.
package uart_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int LED_RX_ACT = 0;
  localparam int LED_TX_ACT = 1;
  localparam int LED_ERR    = 2;
endpackage

// File: rtl/pulse_stretch.sv
// Retriggerable pulse stretcher.
//   clk, rst_n : system clock, synchronous active-low reset
//   trig       : one-cycle strobe, (re)loads the stretch counter
//   out        : high on the trigger cycle and while the counter is nonzero,
//                giving exactly CYC cycles once the caller registers it
module pulse_stretch #(
  parameter int CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trig,
  output logic out
);
  localparam int CW = $clog2(CYC);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)          cnt <= '0;
    else if (trig)       cnt <= CW'(CYC - 1);
    else if (cnt != '0)  cnt <= cnt - CW'(1);
  end

  // Trigger term covers the load cycle so a retrigger never leaves a gap.
  assign out = trig | (cnt != '0);
endmodule

// File: rtl/uart_led_status.sv
// UART status LED driver.
//   clk, rst_n : system clock, synchronous active-low reset
//   rx_data    : received word, qualified by rx_valid
//   rx_valid   : one-cycle strobe, new word received
//   rx_err     : one-cycle strobe, framing/overrun error (sets sticky flag)
//   tx_start   : one-cycle strobe, transmitter accepted a word
//   tx_busy    : level, transmitter shifting
//   mode       : 0 = show last word, 1 = show received-word count
//   err_clr    : one-cycle strobe, clears sticky error
//   led        : registered drive; [DATA_W-1:0] display field, then
//                RX activity, TX activity, blinking error
module uart_led_status
  import uart_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int STRETCH_CYC = 5_000_000,
  parameter int BLINK_DIV   = 25_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              rx_err,
  input  logic              tx_start,
  input  logic              tx_busy,
  input  logic              mode,
  input  logic              err_clr,
  output logic [DATA_W+2:0] led
);
  localparam int LED_RX  = DATA_W + LED_RX_ACT;
  localparam int LED_TX  = DATA_W + LED_TX_ACT;
  localparam int LED_E   = DATA_W + LED_ERR;
  // $clog2(1) is 0; keep at least one bit so the divider is always legal.
  localparam int BW      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [DATA_W-1:0] last_word, last_word_nxt;
  logic [DATA_W-1:0] rx_count,  rx_count_nxt;
  logic              err_flag,  err_nxt;
  logic [BW-1:0]     blink_cnt, blink_cnt_nxt;
  logic              blink_phase, blink_phase_nxt;
  logic              rx_act, tx_act;

  pulse_stretch #(.CYC(STRETCH_CYC)) u_rx_str (
    .clk(clk), .rst_n(rst_n), .trig(rx_valid), .out(rx_act)
  );

  pulse_stretch #(.CYC(STRETCH_CYC)) u_tx_str (
    .clk(clk), .rst_n(rst_n), .trig(tx_start), .out(tx_act)
  );

  always_comb begin
    last_word_nxt   = last_word;
    rx_count_nxt    = rx_count;
    blink_cnt_nxt   = blink_cnt + BW'(1);
    blink_phase_nxt = blink_phase;
    if (rx_valid) begin
      last_word_nxt = rx_data;
      rx_count_nxt  = rx_count + DATA_W'(1);
    end
    // A new error wins over a simultaneous clear.
    err_nxt = rx_err | (err_flag & ~err_clr);
    if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt_nxt   = '0;
      blink_phase_nxt = ~blink_phase;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_word   <= '0;
      rx_count    <= '0;
      err_flag    <= 1'b0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
      led         <= '0;
    end else begin
      last_word   <= last_word_nxt;
      rx_count    <= rx_count_nxt;
      err_flag    <= err_nxt;
      blink_cnt   <= blink_cnt_nxt;
      blink_phase <= blink_phase_nxt;
      // LEDs are driven from next-state values so every input shows up
      // exactly one edge later.
      led[DATA_W-1:0] <= mode ? rx_count_nxt : last_word_nxt;
      led[LED_RX]     <= rx_act;
      led[LED_TX]     <= tx_act | tx_busy;
      led[LED_E]      <= err_nxt & blink_phase_nxt;
    end
  end
endmodule

// File: tb/tb_uart_led_status.sv
module tb_uart_led_status;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] rx_data;
  logic          rx_valid, rx_err, tx_start, tx_busy, mode, err_clr;
  logic [DW+2:0] led;

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;  // edges since last reset edge

  uart_led_status #(.DATA_W(DW), .STRETCH_CYC(4), .BLINK_DIV(3)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_err(rx_err), .tx_start(tx_start), .tx_busy(tx_busy), .mode(mode),
    .err_clr(err_clr), .led(led)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  // Blink phase after k edges: starts 1, flips every 3 edges.
  function automatic logic ph(input int kk);
    return ((kk / 3) % 2) == 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_valid = 1'b1; rx_data = 8'hFF; rx_err = 1'b1;
    tx_start = 1'b1; tx_busy = 1'b1; mode = 1'b0; err_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (led !== 11'h000) begin
        $display("FAIL reset_hold[%0d]: got %h want 000", i, led); n_fail++;
      end
    end
    rx_valid = 1'b0; rx_err = 1'b0; tx_start = 1'b0; tx_busy = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (led !== 11'h000) begin
        $display("FAIL reset_idle[%0d]: got %h want 000", i, led); n_fail++;
      end
    end
  endtask

  task automatic test_rx_word();
    mode = 1'b0; rx_data = 8'hA5; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0; rx_data = 8'h00;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (led[7:0] !== 8'hA5) begin
        $display("FAIL rx_word[%0d]: got %h want a5", i, led[7:0]); n_fail++;
      end
      n_checks++;
      if (led[8] !== (i < 4)) begin
        $display("FAIL rx_stretch[%0d]: got %b want %b", i, led[8], (i < 4)); n_fail++;
      end
      step();
    end
  endtask

  task automatic test_retrigger();
    for (int i = 0; i < 8; i++) begin
      rx_valid = (i == 0 || i == 2);
      rx_data  = (i == 0) ? 8'h3C : 8'h5A;
      step();
      n_checks++;
      if (led[8] !== (i <= 5)) begin
        $display("FAIL retrig[%0d]: got %b want %b", i, led[8], (i <= 5)); n_fail++;
      end
    end
    rx_valid = 1'b0;
    n_checks++;
    if (led[7:0] !== 8'h5A) begin
      $display("FAIL retrig_word: got %h want 5a", led[7:0]); n_fail++;
    end
  endtask

  task automatic test_count_wrap();
    do_reset();
    mode = 1'b1; rx_data = 8'h11;
    for (int n = 1; n <= 257; n++) begin
      rx_valid = 1'b1;
      if (n == 257) rx_data = 8'h77;
      step();
      if (n == 255) begin
        n_checks++;
        if (led[7:0] !== 8'hFF) begin
          $display("FAIL count_255: got %h want ff", led[7:0]); n_fail++;
        end
      end else if (n == 256) begin
        n_checks++;
        if (led[7:0] !== 8'h00) begin
          $display("FAIL count_wrap: got %h want 00", led[7:0]); n_fail++;
        end
      end else if (n == 257) begin
        n_checks++;
        if (led[7:0] !== 8'h01) begin
          $display("FAIL count_257: got %h want 01", led[7:0]); n_fail++;
        end
      end
    end
    rx_valid = 1'b0; mode = 1'b0;
    step();
    n_checks++;
    if (led[7:0] !== 8'h77) begin
      $display("FAIL mode0: got %h want 77", led[7:0]); n_fail++;
    end
    mode = 1'b1;
    step();
    n_checks++;
    if (led[7:0] !== 8'h01) begin
      $display("FAIL mode1: got %h want 01", led[7:0]); n_fail++;
    end
    mode = 1'b0;
  endtask

  task automatic test_error();
    logic exp;
    do_reset();
    rx_err = 1'b1;
    step();
    rx_err = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp = (i == 0) ? 1'b1 : ph(k);
      n_checks++;
      if (led[10] !== exp) begin
        $display("FAIL err_blink[%0d]: got %b want %b", i, led[10], exp); n_fail++;
      end
      if (i < 9) step();
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (led[10] !== 1'b0) begin
        $display("FAIL err_clr[%0d]: got %b want 0", i, led[10]); n_fail++;
      end
      step();
    end
    rx_err = 1'b1; err_clr = 1'b1;
    step();
    rx_err = 1'b0; err_clr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (led[10] !== ph(k)) begin
        $display("FAIL err_both[%0d]: got %b want %b", i, led[10], ph(k)); n_fail++;
      end
      step();
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  task automatic test_tx();
    logic exp;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      tx_busy  = (i < 10);
      tx_start = (i == 0 || i == 9);
      step();
      exp = (i < 10) || (i >= 9 && i <= 12) || (i <= 3);
      n_checks++;
      if (led[9] !== exp) begin
        $display("FAIL tx_act[%0d]: got %b want %b", i, led[9], exp); n_fail++;
      end
    end
    tx_busy = 1'b0; tx_start = 1'b0;
  endtask

  task automatic test_reset_mid_stretch();
    tx_start = 1'b1; rx_valid = 1'b1; rx_data = 8'hC3;
    step();
    tx_start = 1'b0; rx_valid = 1'b0;
    n_checks++;
    if (led[9:8] !== 2'b11) begin
      $display("FAIL mid_pre: got %b want 11", led[9:8]); n_fail++;
    end
    rst_n = 1'b0;
    step();
    n_checks++;
    if (led !== 11'h000) begin
      $display("FAIL mid_rst: got %h want 000", led); n_fail++;
    end
    rst_n = 1'b1;
    step();
    n_checks++;
    if (led !== 11'h000) begin
      $display("FAIL mid_abort: got %h want 000", led); n_fail++;
    end
  endtask

  initial begin
    rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0; rx_err = 1'b0;
    tx_start = 1'b0; tx_busy = 1'b0; mode = 1'b0; err_clr = 1'b0;
    #1;
    test_reset();
    test_rx_word();
    test_retrigger();
    test_count_wrap();
    test_error();
    test_tx();
    test_reset_mid_stretch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_led_status.md
UART_LED_STATUS -- requirements
Module: uart_led_status

Interface
REQ-001 Parameter DATA_W, default 8: width of received data word and of the display field.
REQ-002 Parameter STRETCH_CYC, default 5_000_000: activity-LED on-time in clk cycles, at least 2.
REQ-003 Parameter BLINK_DIV, default 25_000_000: clk cycles per half-period of error blink, at least 1.
REQ-004 clk  in  1: single system clock; all logic on posedge.
REQ-005 rst_n  in  1: reset, synchronous and active-low.
REQ-006 rx_data  in  DATA_W: received word, qualified by rx_valid.
REQ-007 rx_valid  in  1: one-cycle strobe, rx_data valid.
REQ-008 rx_err  in  1: one-cycle strobe, framing/overrun error.
REQ-009 tx_start  in  1: one-cycle strobe, transmitter accepted a word.
REQ-010 tx_busy  in  1: level, transmitter shifting.
REQ-011 mode  in  1: 0 = show last word, 1 = show received-word count.
REQ-012 err_clr  in  1: one-cycle strobe, clears sticky error.
REQ-013 led  out  DATA_W+3: registered LED drive vector.

Function
REQ-014 All led bits SHALL be registered; every response appears on the clk edge after the causing input edge (1-cycle latency).
REQ-015 led[DATA_W-1:0] SHALL show last_word when mode=0 and rx_count when mode=1; a mode change takes effect after 1 cycle.
REQ-016 last_word SHALL load rx_data on each rx_valid and hold otherwise.
REQ-017 rx_count (DATA_W bits) SHALL increment on each rx_valid and wrap from 2^DATA_W-1 to 0.
REQ-018 led[DATA_W] (RX activity) SHALL be a retriggerable stretcher: rx_valid loads counter with STRETCH_CYC-1; LED is high while counter nonzero or on the load cycle; output is high exactly STRETCH_CYC cycles after an isolated strobe.
REQ-019 A retrigger during the stretch SHALL reload the counter, with no low gap on the LED.
REQ-020 led[DATA_W+1] (TX activity) SHALL be a stretcher identical to REQ-018/019, triggered by tx_start, and additionally forced high whenever tx_busy=1.
REQ-021 Sticky error flag SHALL set on rx_err, clear on err_clr, and set if both occur in the same cycle.
REQ-022 Blink divider SHALL be a free-running counter 0..BLINK_DIV-1 toggling blink_phase on wrap; it starts at 0 with phase=1.
REQ-023 led[DATA_W+2] SHALL equal err_flag AND blink_phase.
REQ-024 Counter widths SHALL be $clog2 of the respective parameter; no truncation warnings.

Reset
REQ-025 While rst_n=0 at a clk edge: led=0, last_word=0, rx_count=0, stretch counters=0, err_flag=0, blink counter=0, blink_phase=1.
REQ-026 Reset mid-stretch or mid-blink SHALL abort it immediately; inputs are ignored on reset cycles.

Structure
REQ-027 Shared package uart_pkg SHALL hold the default DATA_W and LED bit-index constants (LED_RX_ACT, LED_TX_ACT, LED_ERR) relative to DATA_W.
REQ-028 Stretcher SHALL be one sub-module pulse_stretch (param CYC; ports clk, rst_n, trig, out), instantiated twice.

Verification (DATA_W=8, STRETCH_CYC=4, BLINK_DIV=3)
REQ-029 Reset then idle -> led=0 for all cycles; at the first cycle with rst_n=1, err LED stays 0.
REQ-030 rx_valid with rx_data=8'hA5, mode=0 -> led[7:0]=A5 next cycle; led[8] high exactly 4 cycles.
REQ-031 rx_valid at t and t+2 -> led[8] high continuously from t+1 to t+6 inclusive.
REQ-032 256 rx_valid strobes, mode=1 -> count reads 0 after wrap; 257th strobe -> 8'h01.
REQ-033 rx_err then err_clr 10 cycles later -> led[10] toggles every 3 cycles, starting high, then 0 after clear; rx_err and err_clr in same cycle -> flag set.
REQ-034 tx_busy high 10 cycles with tx_start on first -> led[9] high for 10 cycles and then holds until the stretch expires; rst_n=0 mid-stretch -> led=0 next cycle.
